// File: rtl/ray_gen.sv
// Camera ray generator: scans an IMG_W x IMG_H grid in raster order and emits
// one primary ray (origin x,y,z then direction x,y,z) per pixel into the
// tracer input FIFO.
// Optional feature: define RAY_GEN_JITTER_EN to add LFSR sub-pixel jitter to
// direction x/y.
module ray_gen #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 10,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [D_BITS-1:0] cam_origin [3],
  input  logic [D_BITS-1:0] pixel_step,
  input  logic [D_BITS-1:0] focal,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [D_BITS-1:0] ray_out [6],
  output logic [XW-1:0]     pixel_x,
  output logic [YW-1:0]     pixel_y,
  output logic              busy,
  output logic              done
);

  // Reject parameter sets the arithmetic cannot represent.
  if (Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_bad_q_bits
    $error("ray_gen: Q_BITS must lie in [0, D_BITS)");
  end
  if (IMG_W < 2 || IMG_H < 2 || (IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_bad_img
    $error("ray_gen: IMG_W and IMG_H must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              load_cfg;
  logic              last_pixel;
  logic [D_BITS-1:0] cfg_origin [3];
  logic [D_BITS-1:0] cfg_step;
  logic [D_BITS-1:0] cfg_focal;
  logic [D_BITS-1:0] off_x;
  logic [D_BITS-1:0] off_y;
  logic [D_BITS-1:0] jit_x;
  logic [D_BITS-1:0] jit_y;

  assign last_pixel = (pixel_x == XW'(IMG_W - 1)) && (pixel_y == YW'(IMG_H - 1));

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobes; the write strobe follows out_full combinationally.
  always_comb begin
    state_next = state;
    out_wr_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_cfg   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_cfg   = 1'b1;
          state_next = GEN;
        end
      end
      GEN: begin
        busy      = 1'b1;
        out_wr_en = !out_full;
        if (!out_full && last_pixel) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame configuration is captured only at an accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_origin[0] <= '0;
      cfg_origin[1] <= '0;
      cfg_origin[2] <= '0;
      cfg_step      <= '0;
      cfg_focal     <= '0;
    end else if (load_cfg) begin
      cfg_origin[0] <= cam_origin[0];
      cfg_origin[1] <= cam_origin[1];
      cfg_origin[2] <= cam_origin[2];
      cfg_step      <= pixel_step;
      cfg_focal     <= focal;
    end
  end

  // Raster counters advance on each write and hold at the final pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (load_cfg) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (out_wr_en && !last_pixel) begin
      if (pixel_x == XW'(IMG_W - 1)) begin
        pixel_x <= '0;
        pixel_y <= pixel_y + 1'b1;
      end else begin
        pixel_x <= pixel_x + 1'b1;
      end
    end
  end

`ifdef RAY_GEN_JITTER_EN
  logic [15:0] lfsr;

  // Galois LFSR, reseeded per frame so every frame sees the same jitter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (load_cfg) begin
      lfsr <= 16'hACE1;
    end else if (out_wr_en) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
  end

  assign jit_x = {{(D_BITS-8){lfsr[7]}}, lfsr[7:0]};
  assign jit_y = {{(D_BITS-8){lfsr[15]}}, lfsr[15:8]};
`else
  assign jit_x = '0;
  assign jit_y = '0;
`endif

  // Centred pixel offsets; an integer offset times a Q value is already Q,
  // and the low D_BITS of the product are kept (silent wrap).
  assign off_x = D_BITS'(pixel_x) - D_BITS'(IMG_W / 2);
  assign off_y = D_BITS'(pixel_y) - D_BITS'(IMG_H / 2);

  // Ray words are a pure function of the latched config and the counters.
  always_comb begin
    ray_out[0] = cfg_origin[0];
    ray_out[1] = cfg_origin[1];
    ray_out[2] = cfg_origin[2];
    ray_out[3] = (off_x * cfg_step) + jit_x;
    ray_out[4] = (off_y * cfg_step) + jit_y;
    ray_out[5] = cfg_focal;
  end

endmodule

// File: tb/tb_ray_gen.sv
// Self-checking bench for ray_gen (IMG_W=4, IMG_H=2) with a behavioural
// reference model of the expected ray stream.
module tb_ray_gen;
  localparam int W = 4;
  localparam int H = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cam_origin [3];
  logic [31:0] pixel_step;
  logic [31:0] focal;
  logic        out_full;
  logic        out_wr_en;
  logic [31:0] ray_out [6];
  logic [1:0]  pixel_x;
  logic [0:0]  pixel_y;
  logic        busy;
  logic        done;

  ray_gen #(.D_BITS(32), .Q_BITS(10), .IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .reset(reset), .start(start), .cam_origin(cam_origin),
    .pixel_step(pixel_step), .focal(focal), .out_full(out_full),
    .out_wr_en(out_wr_en), .ray_out(ray_out), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0][31:0] w;
    int px;
    int py;
    int cyc;
  } rec_t;

  rec_t recs[$];
  int   done_cyc;
  int   stall_bad;
  int   checks = 0;
  int   passed = 0;

  // Jitter pattern for the n-th write of a frame (zero when jitter is off).
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  // Expected word j of the k-th ray of a frame.
  function automatic logic [31:0] exp_word(input int k, input int j,
      input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
      input logic [31:0] stp, input logic [31:0] foc);
    longint      prod;
    logic [31:0] jx;
    logic [31:0] jy;
    logic [15:0] l;
    l  = lfsr_at(k);
`ifdef RAY_GEN_JITTER_EN
    jx = {{24{l[7]}}, l[7:0]};
    jy = {{24{l[15]}}, l[15:8]};
`else
    jx = 32'd0;
    jy = 32'd0;
    l  = 16'd0;
`endif
    case (j)
      0: return o0;
      1: return o1;
      2: return o2;
      3: begin
        prod = longint'((k % W) - W / 2) * longint'($signed(stp));
        return prod[31:0] + jx;
      end
      4: begin
        prod = longint'((k / W) - H / 2) * longint'($signed(stp));
        return prod[31:0] + jy;
      end
      default: return foc;
    endcase
  endfunction

  task automatic set_cfg(input logic [31:0] o0, input logic [31:0] o1,
      input logic [31:0] o2, input logic [31:0] stp, input logic [31:0] foc);
    cam_origin[0] = o0;
    cam_origin[1] = o1;
    cam_origin[2] = o2;
    pixel_step    = stp;
    focal         = foc;
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
  endtask

  // Records every write of one frame; no comparisons here.
  task automatic collect_frame(input int stall_at, input int stall_len,
      input int mid_start_at, input int full_pct, input int stop_at,
      output int timed_out);
    int stall_left;
    bit stalled;
    bit mid_done;
    rec_t r;
    recs.delete();
    done_cyc   = -1;
    stall_bad  = 0;
    stall_left = 0;
    mid_done   = 1'b0;
    timed_out  = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      start   = 1'b0;
      stalled = 1'b0;
      if (stall_left > 0) begin
        out_full = 1'b1;
        stalled = 1'b1;
        stall_left--;
      end else if (full_pct > 0) begin
        out_full = ($urandom_range(99) < full_pct);
      end else begin
        out_full = 1'b0;
      end
      if (mid_start_at >= 0 && !mid_done && recs.size() == mid_start_at) begin
        start = 1'b1;
        pixel_step = 32'd512;
        mid_done = 1'b1;
      end
      #1;
      if (stalled && (out_wr_en !== 1'b0 || int'(pixel_x) != recs.size() % W)) stall_bad++;
      if (out_wr_en === 1'b1) begin
        for (int j = 0; j < 6; j++) r.w[j] = ray_out[j];
        r.px = int'(pixel_x);
        r.py = int'(pixel_y);
        r.cyc = c;
        recs.push_back(r);
        $display("write %0d px=%0d py=%0d o=(%h,%h,%h) d=(%h,%h,%h)", recs.size() - 1,
                 r.px, r.py, r.w[0], r.w[1], r.w[2], r.w[3], r.w[4], r.w[5]);
        if (recs.size() == stall_at) stall_left = stall_len;
        if (recs.size() == stop_at) begin
          timed_out = 0;
          break;
        end
      end
      if (done === 1'b1) begin
        done_cyc = c;
        timed_out = 0;
        break;
      end
    end
    out_full = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    out_full = 1'b0;
    set_cfg(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if ({out_wr_en, busy, done, pixel_x, pixel_y} !== 6'd0)
      $display("FAIL reset_ctrl got wr=%b busy=%b done=%b px=%0d py=%0d required all 0",
               out_wr_en, busy, done, pixel_x, pixel_y);
    else passed++;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (ray_out[j] !== exp_word(0, j, 0, 0, 0, 0, 0))
        $display("FAIL reset_ray%0d got %h required %h", j, ray_out[j], exp_word(0, j, 0, 0, 0, 0, 0));
      else passed++;
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_frame();
    int to;
    set_cfg(32'd1024, 32'd2048, 32'd3072, 32'd1024, 32'd2048);
    do_start();
    collect_frame(-1, 0, -1, 0, -1, to);
    checks++;
    if (to != 0 || recs.size() != 8) $display("FAIL basic_count got %0d writes timeout=%0d required 8", recs.size(), to);
    else passed++;
    for (int k = 0; k < recs.size(); k++) begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (recs[k].w[j] !== exp_word(k, j, 1024, 2048, 3072, 1024, 2048))
          $display("FAIL basic_w%0d_%0d got %h required %h", k, j, recs[k].w[j],
                   exp_word(k, j, 1024, 2048, 3072, 1024, 2048));
        else passed++;
      end
      checks++;
      if (recs[k].px != k % W || recs[k].py != k / W || recs[k].cyc != k)
        $display("FAIL basic_pos%0d got (%0d,%0d)@%0d required (%0d,%0d)@%0d", k,
                 recs[k].px, recs[k].py, recs[k].cyc, k % W, k / W, k);
      else passed++;
    end
`ifndef RAY_GEN_JITTER_EN
    if (recs.size() == 8) begin
      checks++;
      if (recs[0].w[3] !== 32'hFFFF_F800 || recs[0].w[4] !== 32'hFFFF_FC00 ||
          recs[3].w[3] !== 32'd1024 || recs[3].w[4] !== 32'hFFFF_FC00 ||
          recs[7].w[3] !== 32'd1024 || recs[7].w[4] !== 32'd0)
        $display("FAIL basic_literals got d0=(%h,%h) d3=(%h,%h) d7=(%h,%h)",
                 recs[0].w[3], recs[0].w[4], recs[3].w[3], recs[3].w[4], recs[7].w[3], recs[7].w[4]);
      else passed++;
    end
`endif
    checks++;
    if (done_cyc != 8) $display("FAIL basic_done_cycle got %0d required 8", done_cyc);
    else passed++;
    @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_wr_en !== 1'b0)
      $display("FAIL basic_after got busy=%b done=%b wr=%b required 0 0 0", busy, done, out_wr_en);
    else passed++;
  endtask

  task automatic test_backpressure();
    int to;
    set_cfg(32'd1024, 32'd2048, 32'd3072, 32'd1024, 32'd2048);
    do_start();
    collect_frame(2, 5, -1, 0, -1, to);
    checks++;
    if (to != 0 || recs.size() != 8) $display("FAIL bp_count got %0d required 8", recs.size());
    else passed++;
    checks++;
    if (stall_bad != 0) $display("FAIL bp_stall got %0d bad cycles required 0", stall_bad);
    else passed++;
    if (recs.size() == 8) begin
      checks++;
      if (recs[2].cyc != recs[1].cyc + 6) $display("FAIL bp_gap got %0d required %0d", recs[2].cyc, recs[1].cyc + 6);
      else passed++;
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (recs[k].w[3] !== exp_word(k, 3, 1024, 2048, 3072, 1024, 2048) ||
            recs[k].w[4] !== exp_word(k, 4, 1024, 2048, 3072, 1024, 2048))
          $display("FAIL bp_dir%0d got (%h,%h)", k, recs[k].w[3], recs[k].w[4]);
        else passed++;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_start_while_busy();
    int to;
    set_cfg(32'd1024, 32'd2048, 32'd3072, 32'd1024, 32'd2048);
    do_start();
    collect_frame(-1, 0, 4, 0, -1, to);
    checks++;
    if (to != 0 || recs.size() != 8) $display("FAIL busy_start_count got %0d required 8", recs.size());
    else passed++;
    for (int k = 0; k < recs.size(); k++) begin
      checks++;
      if (recs[k].w[3] !== exp_word(k, 3, 1024, 2048, 3072, 1024, 2048) ||
          recs[k].w[4] !== exp_word(k, 4, 1024, 2048, 3072, 1024, 2048))
        $display("FAIL busy_start_dir%0d got (%h,%h)", k, recs[k].w[3], recs[k].w[4]);
      else passed++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    int to;
    set_cfg(32'd1024, 32'd2048, 32'd3072, 32'd1024, 32'd2048);
    do_start();
    collect_frame(-1, 0, -1, 0, 3, to);
    checks++;
    if (to != 0 || recs.size() != 3) $display("FAIL rst_pre got %0d writes required 3", recs.size());
    else passed++;
    @(negedge clock);
    #1;
    checks++;
    if (out_wr_en !== 1'b1) $display("FAIL rst_pre_wr got %b required 1", out_wr_en);
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if (out_wr_en !== 1'b0 || busy !== 1'b0 || pixel_x !== 2'd0)
      $display("FAIL rst_mid got wr=%b busy=%b px=%0d required 0 0 0", out_wr_en, busy, pixel_x);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (out_wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL rst_idle got wr=%b busy=%b required 0 0", out_wr_en, busy);
    else passed++;
    do_start();
    collect_frame(-1, 0, -1, 0, -1, to);
    checks++;
    if (to != 0 || recs.size() != 8 || recs[0].px != 0 || recs[0].py != 0)
      $display("FAIL rst_restart got %0d writes required 8 from (0,0)", recs.size());
    else passed++;
    if (recs.size() > 0) begin
      checks++;
      if (recs[0].w[3] !== exp_word(0, 3, 1024, 2048, 3072, 1024, 2048))
        $display("FAIL rst_restart_dir got %h required %h", recs[0].w[3], exp_word(0, 3, 1024, 2048, 3072, 1024, 2048));
      else passed++;
    end
    @(negedge clock);
  endtask

  task automatic test_wrap_arith();
    int to;
    logic [31:0] steps [3];
    steps[0] = 32'hFFFF_FC00;
    steps[1] = 32'h4000_0000;
    steps[2] = 32'h8000_0000;
    for (int s = 0; s < 3; s++) begin
      set_cfg(32'hFFFF_0000, 32'd7, 32'h7FFF_FFFF, steps[s], 32'hFFFF_F000);
      do_start();
      collect_frame(-1, 0, -1, 0, -1, to);
      checks++;
      if (to != 0 || recs.size() != 8) $display("FAIL wrap%0d_count got %0d required 8", s, recs.size());
      else passed++;
      for (int k = 0; k < recs.size(); k++) begin
        for (int j = 3; j < 5; j++) begin
          checks++;
          if (recs[k].w[j] !== exp_word(k, j, 32'hFFFF_0000, 7, 32'h7FFF_FFFF, steps[s], 32'hFFFF_F000))
            $display("FAIL wrap%0d_w%0d_%0d got %h required %h", s, k, j, recs[k].w[j],
                     exp_word(k, j, 32'hFFFF_0000, 7, 32'h7FFF_FFFF, steps[s], 32'hFFFF_F000));
          else passed++;
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random_frames();
    int to;
    logic [31:0] o0, o1, o2, stp, foc;
    for (int f = 0; f < 4; f++) begin
      o0 = $urandom; o1 = $urandom; o2 = $urandom; stp = $urandom; foc = $urandom;
      set_cfg(o0, o1, o2, stp, foc);
      do_start();
      collect_frame(-1, 0, -1, 35, -1, to);
      checks++;
      if (to != 0 || recs.size() != 8) $display("FAIL rand%0d_count got %0d required 8", f, recs.size());
      else passed++;
      for (int k = 0; k < recs.size(); k++) begin
        for (int j = 0; j < 6; j++) begin
          checks++;
          if (recs[k].w[j] !== exp_word(k, j, o0, o1, o2, stp, foc))
            $display("FAIL rand%0d_w%0d_%0d got %h required %h", f, k, j, recs[k].w[j],
                     exp_word(k, j, o0, o1, o2, stp, foc));
          else passed++;
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_jitter_repeat();
    int to;
    logic [5:0][31:0] first;
    set_cfg(32'd1024, 32'd2048, 32'd3072, 32'd1024, 32'd2048);
    do_start();
    collect_frame(-1, 0, -1, 0, -1, to);
    first = (recs.size() > 0) ? recs[0].w : '0;
    @(negedge clock);
    do_start();
    collect_frame(-1, 0, -1, 0, -1, to);
    checks++;
    if (to != 0 || recs.size() != 8 || recs[0].w !== first)
      $display("FAIL repeat_first got %h required %h", (recs.size() > 0) ? recs[0].w : '0, first);
    else passed++;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    test_wrap_arith();
    test_random_frames();
    test_jitter_repeat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
